// File: rtl/marker_row_scheduler_if.sv
// Signal bundle between the video timing / count_flips detector side and the
// marker row scheduler. The scheduler is the slave; the timing source and bench are the master.
interface marker_row_scheduler_if;
  logic        frame_start_in;
  logic        line_start_in;
  logic [9:0]  vcount_in;
  logic        det_done_in;
  logic [10:0] det_coord_in;
  logic [10:0] det_prob_in;
  logic        det_rst_out;
  logic        row_hit_out;
  logic [10:0] row_x_out;
  logic        marker_valid_out;
  logic [10:0] marker_x_out;
  logic [9:0]  marker_y_out;

  modport slave (
    input  frame_start_in, line_start_in, vcount_in,
    input  det_done_in, det_coord_in, det_prob_in,
    output det_rst_out, row_hit_out, row_x_out,
    output marker_valid_out, marker_x_out, marker_y_out
  );

  modport master (
    output frame_start_in, line_start_in, vcount_in,
    output det_done_in, det_coord_in, det_prob_in,
    input  det_rst_out, row_hit_out, row_x_out,
    input  marker_valid_out, marker_x_out, marker_y_out
  );
endinterface

// File: rtl/marker_row_scheduler.sv
// Drives one count_flips row detector across a frame: best candidate per row,
// vertical run chaining, and one marker centre reported at the next frame start.
module marker_row_scheduler #(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned PROB_THRES = 60,
  parameter int unsigned X_TOL      = 8,
  parameter int unsigned MIN_ROWS   = 4,
  parameter int unsigned MAX_MISS   = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  marker_row_scheduler_if.slave  bus
);

  localparam int CNT_W  = $clog2(RST_CYCLES + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 2);

  typedef enum logic [2:0] {IDLE, ROW_RST, SCAN, ROW_END, FRAME_END} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic               det_rst_q, det_rst_d;
  logic               frame_flag_q, frame_flag_d;
  logic [10:0]        row_best_prob_q, row_best_prob_d;
  logic [10:0]        row_best_x_q, row_best_x_d;
  logic               row_found_q, row_found_d;
  logic [9:0]         run_len_q, run_len_d;
  logic [10:0]        run_x_q, run_x_d;
  logic [9:0]         run_y0_q, run_y0_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [9:0]         frame_best_len_q, frame_best_len_d;
  logic [10:0]        frame_best_x_q, frame_best_x_d;
  logic [9:0]         frame_best_y_q, frame_best_y_d;
  logic               row_hit_q, row_hit_d;
  logic [10:0]        row_x_q, row_x_d;
  logic               marker_valid_q, marker_valid_d;
  logic [10:0]        marker_x_q, marker_x_d;
  logic [9:0]         marker_y_q, marker_y_d;

  logic        accept;
  logic [10:0] x_diff;
  logic [11:0] x_sum;
  logic        close_better;
  logic [9:0]  close_y;
  logic [9:0]  closed_len;
  logic [10:0] closed_x;
  logic [9:0]  closed_y;

  // Strict '<' against the running best keeps the earlier candidate on ties.
  assign accept = bus.det_done_in
               && (bus.det_prob_in < 11'(PROB_THRES))
               && (bus.det_prob_in < row_best_prob_q);

  // Compare before subtracting so the distance never wraps.
  assign x_diff = (row_best_x_q >= run_x_q) ? (row_best_x_q - run_x_q)
                                            : (run_x_q - row_best_x_q);
  assign x_sum  = {1'b0, row_best_x_q} + {1'b0, run_x_q};

  assign close_better = run_len_q > frame_best_len_q;
  assign close_y      = run_y0_q + (run_len_q >> 1);
  assign closed_len   = close_better ? run_len_q : frame_best_len_q;
  assign closed_x     = close_better ? run_x_q   : frame_best_x_q;
  assign closed_y     = close_better ? close_y   : frame_best_y_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d          = state_q;
    rst_cnt_d        = rst_cnt_q;
    frame_flag_d     = frame_flag_q;
    row_best_prob_d  = row_best_prob_q;
    row_best_x_d     = row_best_x_q;
    row_found_d      = row_found_q;
    run_len_d        = run_len_q;
    run_x_d          = run_x_q;
    run_y0_d         = run_y0_q;
    miss_cnt_d       = miss_cnt_q;
    frame_best_len_d = frame_best_len_q;
    frame_best_x_d   = frame_best_x_q;
    frame_best_y_d   = frame_best_y_q;
    row_hit_d        = 1'b0;
    row_x_d          = row_x_q;
    marker_valid_d   = 1'b0;
    marker_x_d       = marker_x_q;
    marker_y_d       = marker_y_q;

    unique case (state_q)
      IDLE: begin
        if (bus.frame_start_in) begin
          state_d   = ROW_RST;
          rst_cnt_d = '0;
        end
      end

      ROW_RST: begin
        row_best_prob_d = '1;
        row_found_d     = 1'b0;
        if (bus.frame_start_in) begin
          // Partial row is dropped; the previous frame is still reported.
          state_d   = FRAME_END;
          rst_cnt_d = '0;
        end else if (bus.line_start_in) begin
          rst_cnt_d = '0;
        end else if (32'(rst_cnt_q) == RST_CYCLES - 1) begin
          state_d = SCAN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      SCAN: begin
        if (accept) begin
          row_best_prob_d = bus.det_prob_in;
          row_best_x_d    = bus.det_coord_in;
          row_found_d     = 1'b1;
        end
        if (bus.frame_start_in) begin
          frame_flag_d = 1'b1;
          state_d      = ROW_END;
        end else if (bus.line_start_in) begin
          state_d = ROW_END;
        end
      end

      ROW_END: begin
        if (row_found_q) begin
          row_hit_d  = 1'b1;
          row_x_d    = row_best_x_q;
          miss_cnt_d = '0;
          if ((run_len_q != 10'd0) && (x_diff <= 11'(X_TOL))) begin
            run_len_d = (run_len_q == 10'h3FF) ? run_len_q : run_len_q + 10'd1;
            run_x_d   = x_sum[11:1];
          end else begin
            if (close_better) begin
              frame_best_len_d = run_len_q;
              frame_best_x_d   = run_x_q;
              frame_best_y_d   = close_y;
            end
            run_len_d = 10'd1;
            run_x_d   = row_best_x_q;
            run_y0_d  = bus.vcount_in;
          end
        end else if (run_len_q != 10'd0) begin
          if (32'(miss_cnt_q) + 1 > MAX_MISS) begin
            if (close_better) begin
              frame_best_len_d = run_len_q;
              frame_best_x_d   = run_x_q;
              frame_best_y_d   = close_y;
            end
            run_len_d  = 10'd0;
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 1'b1;
          end
        end
        if (frame_flag_q || bus.frame_start_in) begin
          frame_flag_d = 1'b0;
          state_d      = FRAME_END;
        end else begin
          state_d   = ROW_RST;
          rst_cnt_d = '0;
        end
      end

      FRAME_END: begin
        if (closed_len >= 10'(MIN_ROWS)) begin
          marker_valid_d = 1'b1;
          marker_x_d     = closed_x;
          marker_y_d     = closed_y;
        end
        frame_best_len_d = '0;
        frame_best_x_d   = '0;
        frame_best_y_d   = '0;
        run_len_d        = '0;
        run_x_d          = '0;
        run_y0_d         = '0;
        miss_cnt_d       = '0;
        frame_flag_d     = 1'b0;
        state_d          = ROW_RST;
        rst_cnt_d        = '0;
      end

      default: state_d = IDLE;
    endcase

    det_rst_d = (state_d != SCAN);
  end

  // NOTE: every register here is a handful of control/data flops, so all of them get an async reset value.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q          <= IDLE;
      rst_cnt_q        <= '0;
      det_rst_q        <= 1'b1;
      frame_flag_q     <= 1'b0;
      row_best_prob_q  <= '0;
      row_best_x_q     <= '0;
      row_found_q      <= 1'b0;
      run_len_q        <= '0;
      run_x_q          <= '0;
      run_y0_q         <= '0;
      miss_cnt_q       <= '0;
      frame_best_len_q <= '0;
      frame_best_x_q   <= '0;
      frame_best_y_q   <= '0;
      row_hit_q        <= 1'b0;
      row_x_q          <= '0;
      marker_valid_q   <= 1'b0;
      marker_x_q       <= '0;
      marker_y_q       <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the values from before this edge.
      state_q          <= state_d;
      rst_cnt_q        <= rst_cnt_d;
      det_rst_q        <= det_rst_d;
      frame_flag_q     <= frame_flag_d;
      row_best_prob_q  <= row_best_prob_d;
      row_best_x_q     <= row_best_x_d;
      row_found_q      <= row_found_d;
      run_len_q        <= run_len_d;
      run_x_q          <= run_x_d;
      run_y0_q         <= run_y0_d;
      miss_cnt_q       <= miss_cnt_d;
      frame_best_len_q <= frame_best_len_d;
      frame_best_x_q   <= frame_best_x_d;
      frame_best_y_q   <= frame_best_y_d;
      row_hit_q        <= row_hit_d;
      row_x_q          <= row_x_d;
      marker_valid_q   <= marker_valid_d;
      marker_x_q       <= marker_x_d;
      marker_y_q       <= marker_y_d;
    end
  end

  assign bus.det_rst_out      = det_rst_q;
  assign bus.row_hit_out      = row_hit_q;
  assign bus.row_x_out        = row_x_q;
  assign bus.marker_valid_out = marker_valid_q;
  assign bus.marker_x_out     = marker_x_q;
  assign bus.marker_y_out     = marker_y_q;

endmodule

// File: tb/tb_marker_row_scheduler.sv
// Directed bench for marker_row_scheduler: frames are described as per-row hit
// tables, expected row hits and markers are queued and checked by a monitor.
module tb_marker_row_scheduler;

  logic clk;
  logic rst_n;

  marker_row_scheduler_if bus ();

  marker_row_scheduler #(
    .RST_CYCLES(2), .PROB_THRES(60), .X_TOL(8), .MIN_ROWS(4), .MAX_MISS(1)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int x;
    int y;
  } marker_t;

  int      exp_row_q[$];
  marker_t exp_mk_q[$];
  int      tbl[0:31];
  int      n_vec = 0;
  int      n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.row_hit_out) begin
        if (exp_row_q.size() == 0) begin
          check("row_hit_spurious", int'(bus.row_hit_out), 0);
        end else begin
          check("row_x", int'(bus.row_x_out), exp_row_q.pop_front());
        end
      end
      if (bus.marker_valid_out) begin
        if (exp_mk_q.size() == 0) begin
          check("marker_spurious", int'(bus.marker_valid_out), 0);
        end else begin
          marker_t m;
          m = exp_mk_q.pop_front();
          check("marker_x", int'(bus.marker_x_out), m.x);
          check("marker_y", int'(bus.marker_y_out), m.y);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Line start pulse; vcount keeps the old row through the commit cycle.
  task automatic line_start(input bit fs, input logic [9:0] v);
    @(negedge clk);
    bus.line_start_in  = 1'b1;
    bus.frame_start_in = fs;
    @(negedge clk);
    bus.line_start_in  = 1'b0;
    bus.frame_start_in = 1'b0;
    @(negedge clk);
    bus.vcount_in = v;
    repeat (5) @(negedge clk);
  endtask

  task automatic det_done(input int coord, input int prob);
    @(negedge clk);
    bus.det_done_in  = 1'b1;
    bus.det_coord_in = 11'(coord);
    bus.det_prob_in  = 11'(prob);
    @(negedge clk);
    bus.det_done_in  = 1'b0;
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 32; i++) tbl[i] = -1;
  endtask

  task automatic fill(input int first, input int last, input int x);
    for (int i = first; i <= last; i++) tbl[i] = x;
  endtask

  // Rows 0..n-1 from tbl (row 0 already scanning), then next frame_start.
  task automatic play_frame(input int n, input bit mk_valid, input int mx, input int my);
    marker_t m;
    for (int v = 0; v < n; v++) begin
      if (v > 0) line_start(1'b0, 10'(v));
      if (tbl[v] >= 0) begin
        det_done(tbl[v], 30);
        exp_row_q.push_back(tbl[v]);
      end
    end
    if (mk_valid) begin
      m.x = mx;
      m.y = my;
      exp_mk_q.push_back(m);
    end
    line_start(1'b1, 10'd0);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.frame_start_in = 1'b0;
    bus.line_start_in  = 1'b0;
    bus.vcount_in      = '0;
    bus.det_done_in    = 1'b0;
    bus.det_coord_in   = '0;
    bus.det_prob_in    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_det_rst", int'(bus.det_rst_out), 1);
    check("rst_row_hit", int'(bus.row_hit_out), 0);
    check("rst_row_x", int'(bus.row_x_out), 0);
    check("rst_marker_valid", int'(bus.marker_valid_out), 0);
    check("rst_marker_x", int'(bus.marker_x_out), 0);
    check("rst_marker_y", int'(bus.marker_y_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First frame_start: detector reset held exactly two cycles
    bus.frame_start_in = 1'b1;
    bus.line_start_in  = 1'b1;
    bus.vcount_in      = 10'd0;
    @(negedge clk);
    bus.frame_start_in = 1'b0;
    bus.line_start_in  = 1'b0;
    check("det_rst_cyc1", int'(bus.det_rst_out), 1);
    @(negedge clk);
    check("det_rst_cyc2", int'(bus.det_rst_out), 1);
    @(negedge clk);
    check("det_rst_released", int'(bus.det_rst_out), 0);
    repeat (3) @(negedge clk);

    // Single row 0: prob 80 and prob 60 rejected, tie at 20 keeps 320
    det_done(300, 80);
    det_done(310, 60);
    det_done(320, 20);
    det_done(340, 20);
    exp_row_q.push_back(320);

    // Run rows 10..15 -> x averages to 400, y = 10 + 3
    clear_tbl();
    fill(10, 10, 400); fill(11, 11, 402); fill(12, 12, 404);
    fill(13, 13, 403); fill(14, 14, 401); fill(15, 15, 400);
    play_frame(16, 1'b1, 400, 13);

    // Only three rows -> below MIN_ROWS
    clear_tbl();
    fill(3, 5, 500);
    play_frame(6, 1'b0, 0, 0);

    // One missing row is bridged: single run of 9 rows starting at 5
    clear_tbl();
    fill(5, 9, 200); fill(11, 14, 201);
    play_frame(15, 1'b1, 200, 9);

    // Two missing rows split runs 5 and 4; the longer first run wins
    clear_tbl();
    fill(5, 9, 200); fill(12, 15, 201);
    play_frame(16, 1'b1, 200, 7);

    // Short run at x=100, longer run at x=600 rows 20..27
    clear_tbl();
    fill(0, 4, 100); fill(20, 27, 600);
    play_frame(28, 1'b1, 600, 24);

    // Reset mid-frame after four committed rows
    for (int v = 0; v < 5; v++) begin
      if (v > 0) line_start(1'b0, 10'(v));
      det_done(100, 30);
      if (v < 4) exp_row_q.push_back(100);
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_det_rst", int'(bus.det_rst_out), 1);
    check("midrst_row_x", int'(bus.row_x_out), 0);
    check("midrst_marker_x", int'(bus.marker_x_out), 0);
    check("midrst_marker_y", int'(bus.marker_y_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    line_start(1'b1, 10'd0);
    for (int v = 1; v < 4; v++) line_start(1'b0, 10'(v));
    line_start(1'b1, 10'd0);
    repeat (10) @(negedge clk);
    check("post_rst_marker_x", int'(bus.marker_x_out), 0);

    check("row_q_drained", exp_row_q.size(), 0);
    check("marker_q_drained", exp_mk_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
